// File: rtl/load_pkg.sv
// Shared definitions for the RISC-V load path: funct3 encodings, the load
// sequencer state type and a legality/alignment helper.
package load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } t_load_state;

    // True when funct3 names a load and the byte offset is naturally aligned for it.
    function automatic logic load_access_ok(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_LB, F3_LBU: return 1'b1;
            F3_LH, F3_LHU: return ~offset[0];
            F3_LW:         return (offset == 2'b00);
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte/half/word extraction and sign/zero extension of a
// memory word; shared with the cache load path.
module load_extend
    import load_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = word[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[offset];
    assign half_sel = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        result = '0;
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LW:   result = word;
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_load_reader.sv
// Single-outstanding RISC-V load sequencer: issues a word-aligned read,
// waits (with timeout) for the response and registers the extended result.
module mem_load_reader
    import load_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [2:0]            i_funct3,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_valid,
    input  logic [31:0]           i_mem_rdata,
    output logic [31:0]           o_read_data,
    output logic                  o_done,
    output logic                  o_busy,
    output logic                  o_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    // Counter starts at 0 on the first WAIT cycle, so the last WAIT cycle holds TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    t_load_state           state_reg, state_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [1:0]            offset_reg, offset_next;
    logic [2:0]            funct3_reg, funct3_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [31:0]           read_data_reg, read_data_next;
    logic                  error_reg, error_next;
    logic [31:0]           ext_data;

    load_extend u_extend (
        .word   (i_mem_rdata),
        .offset (offset_reg),
        .funct3 (funct3_reg),
        .result (ext_data)
    );

    always_comb begin
        state_next     = state_reg;
        mem_addr_next  = mem_addr_reg;
        offset_next    = offset_reg;
        funct3_next    = funct3_reg;
        cnt_next       = cnt_reg;
        read_data_next = read_data_reg;
        error_next     = error_reg;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    mem_addr_next = {i_addr[ADDR_WIDTH-1:2], 2'b00};
                    offset_next   = i_addr[1:0];
                    funct3_next   = i_funct3;
                    cnt_next      = '0;
                    if (load_access_ok(i_funct3, i_addr[1:0])) begin
                        error_next = 1'b0;
                        state_next = REQ;
                    end else begin
                        error_next     = 1'b1;
                        read_data_next = '0;
                        state_next     = DONE;
                    end
                end
            end
            REQ: begin
                if (i_mem_valid) begin
                    read_data_next = ext_data;
                    error_next     = 1'b0;
                    state_next     = DONE;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // A response in the final allowed cycle still beats the timeout.
                if (i_mem_valid) begin
                    read_data_next = ext_data;
                    error_next     = 1'b0;
                    cnt_next       = '0;
                    state_next     = DONE;
                end else if (cnt_reg == CNT_LIMIT) begin
                    read_data_next = '0;
                    error_next     = 1'b1;
                    cnt_next       = '0;
                    state_next     = DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_reg     <= IDLE;
            mem_addr_reg  <= '0;
            offset_reg    <= '0;
            funct3_reg    <= '0;
            cnt_reg       <= '0;
            read_data_reg <= '0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mem_addr_reg  <= mem_addr_next;
            offset_reg    <= offset_next;
            funct3_reg    <= funct3_next;
            cnt_reg       <= cnt_next;
            read_data_reg <= read_data_next;
            error_reg     <= error_next;
        end
    end

    // Status outputs decode the state directly so an async reset clears them at once.
    assign o_mem_req   = (state_reg == REQ);
    assign o_busy      = (state_reg != IDLE);
    assign o_done      = (state_reg == DONE);
    assign o_error     = error_reg;
    assign o_mem_addr  = mem_addr_reg;
    assign o_read_data = read_data_reg;

endmodule

// File: tb/tb_mem_load_reader.sv
// Self-checking bench for mem_load_reader: directed vector table, reset and
// back-to-back sequences, then randomized loads against a behavioural model.
module tb_mem_load_reader;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        arstn;
    logic        i_start;
    logic [31:0] i_addr;
    logic [2:0]  i_funct3;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_valid;
    logic [31:0] i_mem_rdata;
    logic [31:0] o_read_data;
    logic        o_done;
    logic        o_busy;
    logic        o_error;

    int checks = 0;
    int errors = 0;

    mem_load_reader #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .arstn       (arstn),
        .i_start     (i_start),
        .i_addr      (i_addr),
        .i_funct3    (i_funct3),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .i_mem_valid (i_mem_valid),
        .i_mem_rdata (i_mem_rdata),
        .o_read_data (o_read_data),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_error     (o_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] rdata;
        int          w;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        logic        exp_req;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Behavioural model: response arrives w cycles after the request cycle.
    function automatic void ref_load(input logic [31:0] addr, input logic [2:0] f3,
                                     input logic [31:0] rdata, input int w,
                                     output logic [31:0] data, output logic err,
                                     output int lat, output logic req);
        int off;
        int b;
        int h;
        logic legal;
        logic aligned;
        off     = int'(addr[1:0]);
        b       = int'((rdata >> (8 * off)) & 32'hFF);
        h       = int'((rdata >> (16 * (off / 2))) & 32'hFFFF);
        legal   = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        aligned = !(((f3 == 3'd1) || (f3 == 3'd5)) && (off % 2 != 0)) && !((f3 == 3'd2) && (off != 0));
        data = 32'd0;
        if (!legal || !aligned) begin
            err = 1'b1; lat = 1; req = 1'b0;
        end else if (w > T) begin
            err = 1'b1; lat = T + 2; req = 1'b1;
        end else begin
            err = 1'b0; lat = 2 + w; req = 1'b1;
            case (f3)
                3'd0:    data = 32'((b >= 128) ? b - 256 : b);
                3'd1:    data = 32'((h >= 32768) ? h - 65536 : h);
                3'd2:    data = rdata;
                3'd4:    data = 32'(b);
                default: data = 32'(h);
            endcase
        end
    endfunction

    // Entered and left #1 after a rising edge with the DUT in IDLE.
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] rdata, input int w, input logic [31:0] exp_data,
                            input logic exp_err, input int exp_lat, input logic exp_req);
        int          lat;
        int          nreq;
        logic        got_done;
        logic [31:0] req_addr;
        logic [31:0] data;
        logic        err;
        lat = 0; nreq = 0; got_done = 1'b0; req_addr = 32'd0; data = 32'd0; err = 1'b0;
        i_start = 1'b1; i_addr = addr; i_funct3 = f3; i_mem_rdata = rdata;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (o_mem_req) begin
                nreq++;
                req_addr = o_mem_addr;
            end
            if (o_done) begin
                got_done = 1'b1; lat = k; data = o_read_data; err = o_error;
                break;
            end
            i_mem_valid = (k == 1 + w);
            @(posedge clk); #1;
        end
        i_mem_valid = 1'b0;
        check({tag, " done_seen"}, 32'(got_done), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " req_count"}, 32'(nreq), exp_req ? 32'd1 : 32'd0);
        if (exp_req) check({tag, " mem_addr"}, req_addr, {addr[31:2], 2'b00});
        check({tag, " error"}, 32'(err), 32'(exp_err));
        check({tag, " data"}, data, exp_data);
        @(posedge clk); #1;
        check({tag, " busy_after"}, 32'(o_busy), 32'd0);
        check({tag, " data_hold"}, o_read_data, exp_data);
        $display("load %s addr=0x%08h f3=%0d rdata=0x%08h w=%0d -> data=0x%08h err=%0b lat=%0d",
                 tag, addr, f3, rdata, w, data, err, lat);
    endtask

    logic [31:0] m_data;
    logic        m_err;
    int          m_lat;
    logic        m_req;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arstn = 1'b0; i_start = 1'b0; i_addr = '0; i_funct3 = '0;
        i_mem_valid = 1'b0; i_mem_rdata = '0;

        vecs[0]  = '{32'h0000_1003, 3'd0, 32'h80FF_1234, 0, 32'hFFFF_FF80, 1'b0, 2, 1'b1};
        vecs[1]  = '{32'h0000_2002, 3'd5, 32'hBEEF_0000, 3, 32'h0000_BEEF, 1'b0, 5, 1'b1};
        vecs[2]  = '{32'h0000_3001, 3'd2, 32'h1111_1111, 0, 32'h0000_0000, 1'b1, 1, 1'b0};
        vecs[3]  = '{32'h0000_4000, 3'd3, 32'h2222_2222, 0, 32'h0000_0000, 1'b1, 1, 1'b0};
        vecs[4]  = '{32'h0000_5000, 3'd2, 32'h3333_3333, 5, 32'h0000_0000, 1'b1, 6, 1'b1};
        vecs[5]  = '{32'h0000_6004, 3'd2, 32'h1234_5678, 4, 32'h1234_5678, 1'b0, 6, 1'b1};
        vecs[6]  = '{32'h0000_7001, 3'd1, 32'h4444_4444, 0, 32'h0000_0000, 1'b1, 1, 1'b0};
        vecs[7]  = '{32'h0000_7002, 3'd1, 32'h8001_0000, 1, 32'hFFFF_8001, 1'b0, 3, 1'b1};
        vecs[8]  = '{32'h0000_8001, 3'd4, 32'h0000_A500, 0, 32'h0000_00A5, 1'b0, 2, 1'b1};
        vecs[9]  = '{32'h0000_8000, 3'd0, 32'h0000_007F, 2, 32'h0000_007F, 1'b0, 4, 1'b1};
        vecs[10] = '{32'h0000_9000, 3'd6, 32'h5555_5555, 0, 32'h0000_0000, 1'b1, 1, 1'b0};
        vecs[11] = '{32'h0000_9004, 3'd7, 32'h6666_6666, 0, 32'h0000_0000, 1'b1, 1, 1'b0};
        vecs[12] = '{32'h0000_A001, 3'd5, 32'h7777_7777, 0, 32'h0000_0000, 1'b1, 1, 1'b0};
        vecs[13] = '{32'h0000_B000, 3'd1, 32'h1234_F00D, 0, 32'hFFFF_F00D, 1'b0, 2, 1'b1};

        #2;
        check("rst mem_req", 32'(o_mem_req), 32'd0);
        check("rst done", 32'(o_done), 32'd0);
        check("rst busy", 32'(o_busy), 32'd0);
        check("rst error", 32'(o_error), 32'd0);
        check("rst read_data", o_read_data, 32'd0);
        check("rst mem_addr", o_mem_addr, 32'd0);
        @(posedge clk); #1;
        arstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++)
            run_load($sformatf("vec%0d", i), vecs[i].addr, vecs[i].f3, vecs[i].rdata, vecs[i].w,
                     vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_req);

        // Reset asserted mid-WAIT.
        i_start = 1'b1; i_addr = 32'h0000_0100; i_funct3 = 3'd2;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("midwait pre req", 32'(o_mem_req), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midwait pre busy", 32'(o_busy), 32'd1);
        #2 arstn = 1'b0;
        #1;
        check("midwait rst mem_req", 32'(o_mem_req), 32'd0);
        check("midwait rst busy", 32'(o_busy), 32'd0);
        check("midwait rst done", 32'(o_done), 32'd0);
        $display("reset mid-WAIT busy=%0b req=%0b done=%0b", o_busy, o_mem_req, o_done);
        @(posedge clk); #1;
        arstn = 1'b1;
        @(posedge clk); #1;

        // Reset asserted while the request is on the bus, then a late response.
        i_start = 1'b1; i_addr = 32'h0000_0200; i_funct3 = 3'd2;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("midreq pre req", 32'(o_mem_req), 32'd1);
        #2 arstn = 1'b0;
        #1;
        check("midreq rst mem_req", 32'(o_mem_req), 32'd0);
        i_mem_valid = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        arstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("late valid busy", 32'(o_busy), 32'd0);
            check("late valid done", 32'(o_done), 32'd0);
        end
        i_mem_valid = 1'b0;
        $display("reset mid-REQ then late valid, busy=%0b", o_busy);
        run_load("post_reset", 32'h0000_0C02, 3'd1, 32'h7FFF_0000, 1, 32'h0000_7FFF, 1'b0, 3, 1'b1);

        // Back-to-back with i_start held and a zero-wait memory.
        i_addr = 32'h0000_C000; i_funct3 = 3'd2; i_mem_rdata = 32'hCAFE_F00D;
        i_mem_valid = 1'b1; i_start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            check($sformatf("b2b done c%0d", c), 32'(o_done), 32'((c % 3) == 2));
            check($sformatf("b2b req c%0d", c), 32'(o_mem_req), 32'((c % 3) == 1));
            @(posedge clk); #1;
        end
        i_start = 1'b0; i_mem_valid = 1'b0;
        check("b2b data", o_read_data, 32'hCAFE_F00D);
        check("b2b idle", 32'(o_busy), 32'd0);
        $display("back-to-back 12 cycles, data=0x%08h", o_read_data);
        @(posedge clk); #1;

        // Randomized loads against the behavioural model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            logic [2:0]  rf;
            logic [31:0] rd;
            int          rw;
            ra = $urandom;
            rf = 3'($urandom_range(0, 7));
            rd = $urandom;
            rw = $urandom_range(0, 6);
            ref_load(ra, rf, rd, rw, m_data, m_err, m_lat, m_req);
            run_load($sformatf("rnd%0d", i), ra, rf, rd, rw, m_data, m_err, m_lat, m_req);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_load_reader.md
Name: mem_load_reader

Overview:
- Read-side counterpart to the write-enabled nonarchitectural register.
- Performs one RISC-V load transaction at a time:
  - accepts a start pulse with byte address and funct3;
  - issues a word-aligned request to the data memory interface;
  - waits for the response;
  - extracts and sign/zero-extends the byte, half or word;
  - presents a registered result with a one-cycle done pulse.
- Sits between the multi-cycle control unit and the data memory/cache port.

Parameters:
- ADDR_WIDTH, 32, width of load address and memory address bus.
- TIMEOUT_CYCLES, 255, max cycles in WAIT before flagging an error; minimum 1.

Ports:
- clk  input  1  system clock, all state on rising edge
- arstn  input  1  asynchronous active-low reset
- i_start  input  1  start a load; sampled only in IDLE
- i_addr  input  ADDR_WIDTH  byte address of the load
- i_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- o_mem_req  output  1  memory read request
- o_mem_addr  output  ADDR_WIDTH  word-aligned address, i_addr with [1:0] forced to 0
- i_mem_valid  input  1  memory response valid
- i_mem_rdata  input  32  memory response word
- o_read_data  output  32  extended load result; registered
- o_done  output  1  one-cycle pulse: result or error available
- o_busy  output  1  high in any state other than IDLE
- o_error  output  1  valid with o_done: misaligned, illegal funct3 or timeout

Behaviour:
- Reset is asynchronous on arstn low. Reset values:
  - state IDLE;
  - o_mem_req, o_done, o_busy, o_error = 0;
  - o_read_data and o_mem_addr = 0;
  - timeout counter = 0.
- Reset mid-transaction drops o_mem_req immediately. Any late i_mem_valid is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On i_start, capture address, funct3 and byte offset i_addr[1:0].
  - If funct3 is illegal (011, 110, 111), or the access is misaligned (LH/LHU with addr[0]=1; LW with addr[1:0]≠0): go to DONE with error=1. No memory request is issued.
  - Otherwise go to REQ.
- REQ:
  - o_mem_req=1 and o_mem_addr valid.
  - If i_mem_valid is high in the same cycle, capture the result and go to DONE.
  - Otherwise go to WAIT.
- WAIT:
  - o_mem_req=0; counter increments each cycle.
  - On i_mem_valid: capture the result, clear the counter, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES without valid: error=1, o_read_data=0, go to DONE.
  - When valid and timeout coincide, valid wins.
- DONE:
  - o_done=1 for exactly one cycle; o_error is meaningful only while o_done=1.
  - Go to IDLE next cycle.
  - i_start in DONE is ignored; a new start is accepted in IDLE only.
- Extraction from i_mem_rdata by offset:
  - byte = rdata[8*off +: 8];
  - half = rdata[16*off[1] +: 16];
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- o_read_data holds its value until the next completion. On an error completion it is written to 0.
- i_mem_valid outside REQ/WAIT is ignored.
- Latency: start in cycle 0, REQ in cycle 1. With valid in cycle 1, o_done is high in cycle 2. Each WAIT cycle adds one.
- Error path latency: start in cycle 0, o_done in cycle 1.
- Timeout: with no response, o_done rises TIMEOUT_CYCLES+2 cycles after the start cycle.

Decomposition:
- Shared package load_pkg holds:
  - funct3 load constants (LB, LH, LW, LBU, LHU);
  - state enum t_load_state {IDLE, REQ, WAIT, DONE}.
- One natural combinational sub-module, load_extend: inputs word, offset and funct3; output is the extended 32-bit result. It is reused by the cache's load path.

Test Plan:
- Reset: assert arstn low mid-WAIT → o_mem_req, o_busy, o_done drop to 0 asynchronously. Next start behaves normally.
- LB with addr 0x1003, memory returns 0x80FF_1234 in cycle 1:
  - o_mem_addr=0x1000;
  - o_done in cycle 2;
  - o_read_data=0xFFFF_FF80.
- LHU with addr 0x2002, rdata 0xBEEF_0000, valid after 3 WAIT cycles:
  - o_read_data=0x0000_BEEF;
  - o_done in cycle 5.
- LW with addr 0x3001 → no o_mem_req; o_done in cycle 1 with o_error=1, o_read_data=0. funct3=011 behaves the same.
- Timeout with TIMEOUT_CYCLES=4 and no valid:
  - o_done with o_error=1 four cycles after entering WAIT.
  - Valid arriving in the same cycle as the limit → no error, data captured.
- Back-to-back: i_start held high continuously → starts accepted only in IDLE, one transaction per 3 cycles with zero-wait memory. i_start in DONE has no effect.
